// File: rtl/mem_refill_responder_pkg.sv
// Shared encodings and block-geometry helpers for the cache refill responder.
package mem_refill_responder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    localparam int DEFAULT_WORDS = 8;
    localparam int BLK_OFF_W     = $clog2(2 * DEFAULT_WORDS);

    // Byte-offset width inside a block of `words` 16-bit words.
    function automatic int blk_off_w(input int words);
        return $clog2(2 * words);
    endfunction

endpackage

// File: rtl/mem_refill_responder_if.sv
// Cache-miss request, refill broadcast and main-memory read signals.
interface mem_refill_responder_if;

    logic        IReq;
    logic [15:0] IAddr;
    logic        DReq;
    logic [15:0] DAddr;
    logic [15:0] MemData;
    logic [15:0] MemAddress;
    logic        ICacheWriteEnable;
    logic        DCacheWriteEnable;
    logic        IMemStall;
    logic        DMemStall;
    logic        MemEnable;
    logic [15:0] MemReadAddr;
    logic [15:0] MemReadData;
    logic        MemDataValid;

    modport slave (
        input  IReq, IAddr, DReq, DAddr, MemReadData, MemDataValid,
        output MemData, MemAddress, ICacheWriteEnable, DCacheWriteEnable,
               IMemStall, DMemStall, MemEnable, MemReadAddr
    );

    modport master (
        output IReq, IAddr, DReq, DAddr, MemReadData, MemDataValid,
        input  MemData, MemAddress, ICacheWriteEnable, DCacheWriteEnable,
               IMemStall, DMemStall, MemEnable, MemReadAddr
    );

endinterface

// File: rtl/mem_refill_responder_refill_counter.sv
// Word counter for one refill: synchronous clear, increment, terminal flag at WORDS-1.
module refill_counter #(
    parameter int WORDS = 8,
    parameter int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/mem_refill_responder.sv
// Services one I- or D-cache block refill at a time from a pipelined main memory.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a miss; D has priority over I
// ISSUE    | one memory read per cycle until all WORDS reads are issued
// DRAIN    | all reads issued, collecting remaining returns
// DONE     | block complete; granted port's stall drops for one cycle
module mem_refill_responder
    import mem_refill_responder_pkg::*;
#(
    parameter int WORDS   = 8,
    parameter int LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_refill_responder_if.slave  bus
);

    localparam int          CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int          OFF_W    = blk_off_w(WORDS);
    localparam logic [15:0] OFF_MASK = 16'((1 << OFF_W) - 1);

    logic [1:0]       state, state_nxt;
    logic             grant, grant_nxt;
    logic [15:0]      base, base_nxt;
    logic [CNT_W-1:0] issue_cnt, recv_cnt;
    logic             issue_tc, recv_tc;
    logic             grab, issue_inc, recv_inc;
    logic [15:0]      recv_addr;
    logic [15:0]      data_q, addr_q;

    assign grab      = (state == ST_IDLE) && (bus.DReq || bus.IReq);
    assign issue_inc = (state == ST_ISSUE);
    // Returns are only meaningful while a refill is collecting words.
    assign recv_inc  = ((state == ST_ISSUE) || (state == ST_DRAIN)) && bus.MemDataValid;
    assign recv_addr = base + 16'({recv_cnt, 1'b0});

    refill_counter #(.WORDS(WORDS), .CNT_W(CNT_W)) u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .clr (grab),
        .inc (issue_inc),
        .cnt (issue_cnt),
        .tc  (issue_tc)
    );

    refill_counter #(.WORDS(WORDS), .CNT_W(CNT_W)) u_recv_cnt (
        .clk (clk),
        .rst (rst),
        .clr (grab),
        .inc (recv_inc),
        .cnt (recv_cnt),
        .tc  (recv_tc)
    );

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        base_nxt  = base;
        case (state)
            ST_IDLE: begin
                if (bus.DReq) begin
                    grant_nxt = GRANT_D;
                    base_nxt  = bus.DAddr & ~OFF_MASK;
                    state_nxt = ST_ISSUE;
                end else if (bus.IReq) begin
                    grant_nxt = GRANT_I;
                    base_nxt  = bus.IAddr & ~OFF_MASK;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (recv_inc && recv_tc) begin
                    state_nxt = ST_DONE;
                end else if (issue_tc) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (recv_inc && recv_tc) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            grant  <= GRANT_I;
            base   <= 16'h0000;
            data_q <= 16'h0000;
            addr_q <= 16'h0000;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            base  <= base_nxt;
            if (recv_inc) begin
                data_q <= bus.MemReadData;
                addr_q <= recv_addr;
            end
        end
    end

    assign bus.MemEnable   = issue_inc;
    assign bus.MemReadAddr = issue_inc ? (base + 16'({issue_cnt, 1'b0})) : 16'h0000;

    // Refill word is passed through on the return cycle, otherwise held.
    assign bus.MemData           = recv_inc ? bus.MemReadData : data_q;
    assign bus.MemAddress        = recv_inc ? recv_addr : addr_q;
    assign bus.ICacheWriteEnable = recv_inc && (grant == GRANT_I);
    assign bus.DCacheWriteEnable = recv_inc && (grant == GRANT_D);

    // Stalls are qualified by reset so every output reads zero while reset is held.
    assign bus.IMemStall = rst && bus.IReq && !((state == ST_DONE) && (grant == GRANT_I));
    assign bus.DMemStall = rst && bus.DReq && !((state == ST_DONE) && (grant == GRANT_D));

endmodule
